wb_regfile_sb: RTL and testbench
================================

// Module: wb_regfile_sb
// PURPOSE
//  Parametrised writeback stage plus integer register file with a per-register busy scoreboard.
//  Accepts NWB writeback channels, holds each for one staged cycle, then commits to the architectural GPRs.
//  Provides NRD read ports to decode, and tracks in-flight writers so issue logic can detect RAW hazards.
//  Sits after MEM (or after parallel LSU/ALU result paths) and feeds decode/issue and the difftest commit probe.
// PARAMETERS
//  XLEN   64  data width of each GPR
//  NREG   32  register count; x0 is hard-wired zero; RW=$clog2(NREG)
//  NRD    2   number of combinational read ports
//  NWB    2   number of writeback channels; a higher index is younger
//  CNT_W  2   width of the per-register in-flight writer counter
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active-high
//  in_valid     in   NWB        per-channel result valid from the previous stage
//  in_allowin   out  NWB        per-channel stage ready (back-pressure to the previous stage)
//  in_wen       in   NWB        channel writes a GPR
//  in_rd        in   NWB*RW     destination index, packed with channel c at [c*RW +: RW]
//  in_data      in   NWB*XLEN   result data, packed
//  flush        in   1          pipeline flush (trap/redirect)
//  commit_stall in   1          holds the staged entries (debug/difftest back-pressure)
//  issue_valid  in   1          an instruction with a destination is issued this cycle
//  issue_rd     in   RW         destination of the issuing instruction
//  issue_ready  out  1          cnt[issue_rd] is not saturated
//  raddr        in   NRD*RW     read addresses, packed
//  rdata        out  NRD*XLEN   read data, packed
//  busy         out  NREG       busy[i] = (cnt[i]!=0); bit 0 is always 0
//  cmt_valid    out  NWB        channel commits this cycle
//  cmt_rd       out  NWB*RW     committing destination
//  cmt_data     out  NWB*XLEN   committing data
// BEHAVIOUR
//  - Reset (one edge): stage valid=0, all counters=0, GPRs x1..x(NREG-1)=0.
//    Outputs after reset: cmt_valid=0, busy=0, rdata=0, issue_ready=1.
//  - Stage: in_allowin[c] = !stg_valid[c] | !commit_stall.
//    When in_allowin[c]: stg_valid[c] <= in_valid[c] & !flush; payload is loaded only if in_valid[c].
//  - Commit: cmt_valid[c] = stg_valid[c] & !commit_stall. cmt_rd/cmt_data are driven directly from the stage registers.
//    GPR write occurs at the edge ending the commit cycle when cmt_valid[c] & wen & rd!=0.
//    Latency: in_valid at cycle N gives commit at N+1; the value is readable from the GPR array at N+2.
//  - Same rd committed on several channels in one cycle: the highest channel index wins.
//  - flush kills only incoming entries. Already-staged entries commit normally (they are older than the flush point).
//  - Scoreboard, per register r!=0:
//    - inc = issue_valid & issue_rd==r & issue_ready.
//    - dec = number of channels committing with wen & rd==r.
//    - cnt <= cnt + inc - dec, clamped at 0 (never wraps below 0).
//    - flush: cnt <= 0 for all registers; flush beats a simultaneous issue.
//    - issue to rd=0: ignored, never busy.
//    - cnt at 2^CNT_W-1: issue_ready=0, and the issue is not counted.
//  - Read: rdata = 0 when raddr==0, else the GPR value (subject to bypass below).
//  - Reset in mid-operation: staged entries are dropped without a GPR write; counters are zeroed.
// CONFIGURATION
//  WB_RF_BYPASS_EN defined:
//    - rdata returns the data of the highest-index stg_valid & wen & rd==raddr entry, else the GPR value.
//    - The bypass ignores commit_stall, so a stalled value is still forwarded.
//  WB_RF_BYPASS_EN undefined:
//    - rdata returns GPR contents only; consumers must wait until busy clears plus one cycle.
// STRUCTURE
//  - Package wb_rf_pkg holds XLEN, NREG, RW, CNT_W, typedef regidx_t (logic[RW-1:0]),
//    typedef xdata_t (logic[XLEN-1:0]), and the struct wb_entry_t {wen, rd, data}.
//  - Sub-module wb_rf_scoreboard holds the counters, inc/dec/clamp/flush logic, busy and issue_ready.
//  - The GPR array and stage registers live in the top level.
// TESTING
//  1. Reset, then in_valid[0], wen, rd=5, data=64'hDEAD -> cmt_valid[0]=1 next cycle; raddr=5 reads 64'hDEAD one cycle later.
//  2. Both channels in one cycle with rd=7, data A (ch0) and B (ch1) -> rf[7]=B; with bypass, raddr=7 returns B during the commit cycle.
//  3. issue_rd=3 three times (CNT_W=2) -> busy[3]=1, issue_ready=0 on the 4th issue; three commits to rd=3 -> busy[3]=0.
//  4. flush together with in_valid[0] and issue_valid -> the entry never commits; all busy=0 next cycle; the older staged entry still commits.
//  5. commit_stall=1 for 3 cycles with a staged rd=9 -> cmt_valid=0, in_allowin=0, rf[9] unchanged; commit occurs on the cycle stall drops.
//  6. Write to rd=0 and issue to rd=0 -> rdata for x0 stays 0, busy[0]=0; rst asserted mid-stall -> no GPR write, cmt_valid=0.

Source files
------------

// File: rtl/wb_rf_pkg.sv
// Shared types and sizing for the writeback stage and register file.
package wb_rf_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREG  = 32;
  localparam int unsigned RW    = $clog2(NREG);
  localparam int unsigned CNT_W = 2;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWB   = 2;

  typedef logic [RW-1:0]    regidx_t;
  typedef logic [XLEN-1:0]  xdata_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic    wen;
    regidx_t rd;
    xdata_t  data;
  } wb_entry_t;

  localparam cnt_t CntMax = {CNT_W{1'b1}};

endpackage

// File: rtl/wb_rf_scoreboard.sv
// Per-register in-flight writer counters; drives busy and issue back-pressure.
module wb_rf_scoreboard
  import wb_rf_pkg::*;
#(
  parameter int unsigned NumWb = NWB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  regidx_t             issue_rd_i,
  input  logic [NumWb-1:0]    cmt_valid_i,
  input  logic [NumWb-1:0]    cmt_wen_i,
  input  logic [NumWb*RW-1:0] cmt_rd_i,
  output logic [NREG-1:0]     busy_o,
  output logic                issue_ready_o
);

  // Wide enough for cnt + 1 and for NumWb simultaneous decrements.
  localparam int unsigned SumW = CNT_W + $clog2(NumWb + 1) + 1;

  cnt_t cnt_q [NREG];
  cnt_t cnt_d [NREG];

  logic [SumW-1:0] sum;
  logic [SumW-1:0] dec;

  assign issue_ready_o = (cnt_q[issue_rd_i] != CntMax);

  always_comb begin
    sum = '0;
    dec = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      dec = '0;
      for (int unsigned c = 0; c < NumWb; c++) begin
        if (cmt_valid_i[c] && cmt_wen_i[c] && (cmt_rd_i[c*RW +: RW] == regidx_t'(r))) begin
          dec = dec + SumW'(1);
        end
      end
      sum = SumW'(cnt_q[r]);
      if (issue_valid_i && (issue_rd_i == regidx_t'(r)) && issue_ready_o) begin
        sum = sum + SumW'(1);
      end
      // x0 never tracks writers; flush outranks any same-cycle issue.
      if (flush_i || (r == 0)) begin
        cnt_d[r] = '0;
      end else if (sum > dec) begin
        cnt_d[r] = cnt_t'(sum - dec);
      end else begin
        cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    busy_o = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      busy_o[r] = (cnt_q[r] != '0);
    end
  end

endmodule

// File: rtl/wb_regfile_sb.sv
// Writeback stage, GPR file and busy scoreboard. Defining WB_RF_BYPASS_EN forwards staged
// results to the read ports.
module wb_regfile_sb
  import wb_rf_pkg::*;
#(
  parameter int unsigned NumRd = NRD,
  parameter int unsigned NumWb = NWB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NumWb-1:0]      in_valid,
  output logic [NumWb-1:0]      in_allowin,
  input  logic [NumWb-1:0]      in_wen,
  input  logic [NumWb*RW-1:0]   in_rd,
  input  logic [NumWb*XLEN-1:0] in_data,
  input  logic                  flush,
  input  logic                  commit_stall,
  input  logic                  issue_valid,
  input  regidx_t               issue_rd,
  output logic                  issue_ready,
  input  logic [NumRd*RW-1:0]   raddr,
  output logic [NumRd*XLEN-1:0] rdata,
  output logic [NREG-1:0]       busy,
  output logic [NumWb-1:0]      cmt_valid,
  output logic [NumWb*RW-1:0]   cmt_rd,
  output logic [NumWb*XLEN-1:0] cmt_data
);

  logic [NumWb-1:0] stg_valid_q, stg_valid_d;
  wb_entry_t        stg_q [NumWb];
  wb_entry_t        stg_d [NumWb];
  xdata_t           rf_q  [NREG];
  xdata_t           rf_d  [NREG];
  logic [NumWb-1:0] cmt_wen;
  regidx_t          rd_addr;
  xdata_t           rd_val;

  assign in_allowin = ~stg_valid_q | {NumWb{~commit_stall}};

  always_comb begin
    stg_valid_d = stg_valid_q;
    for (int unsigned c = 0; c < NumWb; c++) begin
      stg_d[c] = stg_q[c];
      if (in_allowin[c]) begin
        // Flush only blocks new entries; anything already staged is older and still commits.
        stg_valid_d[c] = in_valid[c] && !flush;
        if (in_valid[c]) begin
          stg_d[c].wen  = in_wen[c];
          stg_d[c].rd   = in_rd[c*RW +: RW];
          stg_d[c].data = in_data[c*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    cmt_valid = '0;
    cmt_wen   = '0;
    cmt_rd    = '0;
    cmt_data  = '0;
    for (int unsigned c = 0; c < NumWb; c++) begin
      cmt_valid[c]              = stg_valid_q[c] && !commit_stall;
      cmt_wen[c]                = stg_q[c].wen;
      cmt_rd[c*RW +: RW]        = stg_q[c].rd;
      cmt_data[c*XLEN +: XLEN]  = stg_q[c].data;
    end
  end

  // Ascending channel order lets the youngest channel win a same-rd collision.
  always_comb begin
    rf_d = rf_q;
    for (int unsigned c = 0; c < NumWb; c++) begin
      if (cmt_valid[c] && stg_q[c].wen && (stg_q[c].rd != '0)) begin
        rf_d[stg_q[c].rd] = stg_q[c].data;
      end
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid_q <= '0;
      for (int unsigned c = 0; c < NumWb; c++) begin
        stg_q[c] <= '0;
      end
      for (int unsigned r = 0; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      stg_valid_q <= stg_valid_d;
      for (int unsigned c = 0; c < NumWb; c++) begin
        stg_q[c] <= stg_d[c];
      end
      for (int unsigned r = 0; r < NREG; r++) begin
        rf_q[r] <= rf_d[r];
      end
    end
  end

  always_comb begin
    rdata   = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int unsigned p = 0; p < NumRd; p++) begin
      rd_addr = raddr[p*RW +: RW];
      rd_val  = rf_q[rd_addr];
`ifdef WB_RF_BYPASS_EN
      // Forwarding deliberately ignores commit_stall.
      for (int unsigned c = 0; c < NumWb; c++) begin
        if (stg_valid_q[c] && stg_q[c].wen && (stg_q[c].rd == rd_addr)) begin
          rd_val = stg_q[c].data;
        end
      end
`endif
      if (rd_addr == '0) begin
        rd_val = '0;
      end
      rdata[p*XLEN +: XLEN] = rd_val;
    end
  end

  wb_rf_scoreboard #(
    .NumWb(NumWb)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .cmt_valid_i  (cmt_valid),
    .cmt_wen_i    (cmt_wen),
    .cmt_rd_i     (cmt_rd),
    .busy_o       (busy),
    .issue_ready_o(issue_ready)
  );

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed scenarios plus randomized traffic checked against a behavioural model.
module tb_wb_regfile_sb;
  import wb_rf_pkg::*;

  localparam int unsigned NumRd = NRD;
  localparam int unsigned NumWb = NWB;
  localparam int CntSat = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NumWb-1:0]      in_valid;
  logic [NumWb-1:0]      in_allowin;
  logic [NumWb-1:0]      in_wen;
  logic [NumWb*RW-1:0]   in_rd;
  logic [NumWb*XLEN-1:0] in_data;
  logic                  flush;
  logic                  commit_stall;
  logic                  issue_valid;
  regidx_t               issue_rd;
  logic                  issue_ready;
  logic [NumRd*RW-1:0]   raddr;
  logic [NumRd*XLEN-1:0] rdata;
  logic [NREG-1:0]       busy;
  logic [NumWb-1:0]      cmt_valid;
  logic [NumWb*RW-1:0]   cmt_rd;
  logic [NumWb*XLEN-1:0] cmt_data;

  always #5 clk = ~clk;

  wb_regfile_sb #(
    .NumRd(NumRd),
    .NumWb(NumWb)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_allowin  (in_allowin),
    .in_wen      (in_wen),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .flush       (flush),
    .commit_stall(commit_stall),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .raddr       (raddr),
    .rdata       (rdata),
    .busy        (busy),
    .cmt_valid   (cmt_valid),
    .cmt_rd      (cmt_rd),
    .cmt_data    (cmt_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers, writer counts, and the pending result per channel.
  logic [63:0] m_rf   [NREG];
  int          m_cnt  [NREG];
  bit          m_v    [NumWb];
  bit          m_wen  [NumWb];
  int          m_rd   [NumWb];
  logic [63:0] m_data [NumWb];

  task automatic m_reset();
    for (int r = 0; r < NREG; r++) begin
      m_rf[r]  = '0;
      m_cnt[r] = 0;
    end
    for (int c = 0; c < NumWb; c++) begin
      m_v[c]    = 1'b0;
      m_wen[c]  = 1'b0;
      m_rd[c]   = 0;
      m_data[c] = '0;
    end
  endtask

  function automatic logic [63:0] m_read(input int a);
    logic [63:0] v;
    if (a == 0) return '0;
    v = m_rf[a];
`ifdef WB_RF_BYPASS_EN
    for (int c = 0; c < NumWb; c++) begin
      if (m_v[c] && m_wen[c] && m_rd[c] == a) v = m_data[c];
    end
`endif
    return v;
  endfunction

  task automatic idle();
    rst          = 1'b0;
    in_valid     = '0;
    in_wen       = '0;
    in_rd        = '0;
    in_data      = '0;
    flush        = 1'b0;
    commit_stall = 1'b0;
    issue_valid  = 1'b0;
    issue_rd     = '0;
    raddr        = '0;
  endtask

  task automatic wb(input int c, input int rd, input logic [63:0] d);
    in_valid[c]              = 1'b1;
    in_wen[c]                = 1'b1;
    in_rd[c*RW +: RW]        = RW'(rd);
    in_data[c*XLEN +: XLEN]  = d;
  endtask

  // Compare current outputs with the model, then advance the model over the coming edge.
  task automatic cycle();
    int          dec [NREG];
    int          n;
    logic [31:0] exp_busy;
    @(negedge clk);
    for (int c = 0; c < NumWb; c++) begin
      check_eq($sformatf("allowin%0d", c), in_allowin[c], !m_v[c] || !commit_stall);
      check_eq($sformatf("cmt_valid%0d", c), cmt_valid[c], m_v[c] && !commit_stall);
      if (m_v[c] && !commit_stall) begin
        check_eq($sformatf("cmt_rd%0d", c), cmt_rd[c*RW +: RW], m_rd[c]);
        check_eq($sformatf("cmt_data%0d", c), cmt_data[c*XLEN +: XLEN], m_data[c]);
      end
    end
    exp_busy = '0;
    for (int r = 0; r < NREG; r++) exp_busy[r] = (m_cnt[r] != 0);
    check_eq("busy", busy, exp_busy);
    check_eq("issue_ready", issue_ready, m_cnt[issue_rd] < CntSat);
    for (int p = 0; p < NumRd; p++) begin
      check_eq($sformatf("rdata%0d", p), rdata[p*XLEN +: XLEN], m_read(int'(raddr[p*RW +: RW])));
    end

    if (rst) begin
      m_reset();
    end else begin
      for (int r = 0; r < NREG; r++) dec[r] = 0;
      for (int c = 0; c < NumWb; c++) begin
        if (m_v[c] && !commit_stall && m_wen[c]) begin
          dec[m_rd[c]]++;
          if (m_rd[c] != 0) m_rf[m_rd[c]] = m_data[c];
        end
      end
      for (int r = 1; r < NREG; r++) begin
        if (flush) begin
          m_cnt[r] = 0;
        end else begin
          n = m_cnt[r] - dec[r];
          if (issue_valid && int'(issue_rd) == r && m_cnt[r] < CntSat) n++;
          m_cnt[r] = (n < 0) ? 0 : n;
        end
      end
      m_cnt[0] = 0;
      for (int c = 0; c < NumWb; c++) begin
        if (!m_v[c] || !commit_stall) begin
          m_v[c] = in_valid[c] && !flush;
          if (in_valid[c]) begin
            m_wen[c]  = in_wen[c];
            m_rd[c]   = int'(in_rd[c*RW +: RW]);
            m_data[c] = in_data[c*XLEN +: XLEN];
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] ValA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] ValB = 64'h5555_6666_7777_8888;
  localparam logic [63:0] ValZ = 64'h0000_0000_0000_9999;

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_reset();
    idle();
    raddr[RW-1:0] = RW'(5);
    #1;
    check_eq("rst_cmt_valid", cmt_valid, '0);
    check_eq("rst_busy", busy, '0);
    check_eq("rst_rdata", rdata[XLEN-1:0], '0);
    check_eq("rst_issue_ready", issue_ready, 1'b1);

    // Basic commit latency and readback.
    wb(0, 5, 64'hDEAD);
    cycle();
    idle();
    #1;
    check_eq("t1_cmt_valid", cmt_valid[0], 1'b1);
    check_eq("t1_cmt_data", cmt_data[XLEN-1:0], 64'hDEAD);
    cycle();
    idle();
    raddr[RW-1:0] = RW'(5);
    #1;
    check_eq("t1_read", rdata[XLEN-1:0], 64'hDEAD);
    cycle();

    // Same rd on both channels: the younger channel wins.
    idle();
    wb(0, 7, ValA);
    wb(1, 7, ValB);
    cycle();
    idle();
    raddr[RW-1:0] = RW'(7);
    #1;
`ifdef WB_RF_BYPASS_EN
    check_eq("t2_bypass", rdata[XLEN-1:0], ValB);
`else
    check_eq("t2_no_bypass", rdata[XLEN-1:0], '0);
`endif
    cycle();
    idle();
    raddr[RW-1:0] = RW'(7);
    #1;
    check_eq("t2_rf7", rdata[XLEN-1:0], ValB);
    cycle();

    // Counter saturation and drain.
    for (int i = 0; i < 3; i++) begin
      idle();
      issue_valid = 1'b1;
      issue_rd    = RW'(3);
      cycle();
    end
    idle();
    issue_valid = 1'b1;
    issue_rd    = RW'(3);
    #1;
    check_eq("t3_ready_sat", issue_ready, 1'b0);
    check_eq("t3_busy3", busy[3], 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      wb(0, 3, 64'(i));
      cycle();
    end
    idle();
    cycle();
    idle();
    #1;
    check_eq("t3_busy3_clear", busy[3], 1'b0);
    cycle();

    // Flush kills the incoming entry but not the staged one.
    idle();
    wb(0, 4, 64'h44);
    issue_valid = 1'b1;
    issue_rd    = RW'(6);
    cycle();
    idle();
    wb(0, 6, 64'h66);
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_rd    = RW'(6);
    #1;
    check_eq("t4_old_commits", cmt_valid[0], 1'b1);
    cycle();
    idle();
    #1;
    check_eq("t4_busy_clear", busy, '0);
    check_eq("t4_killed", cmt_valid, '0);
    cycle();

    // Commit stall holds the staged entry.
    idle();
    wb(0, 9, ValZ);
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      commit_stall  = 1'b1;
      raddr[RW-1:0] = RW'(9);
      #1;
      check_eq("t5_stall_cmt", cmt_valid[0], 1'b0);
      check_eq("t5_stall_allowin", in_allowin[0], 1'b0);
`ifdef WB_RF_BYPASS_EN
      check_eq("t5_stall_fwd", rdata[XLEN-1:0], ValZ);
`else
      check_eq("t5_stall_rf9", rdata[XLEN-1:0], '0);
`endif
      cycle();
    end
    idle();
    #1;
    check_eq("t5_release", cmt_valid[0], 1'b1);
    cycle();
    idle();
    raddr[RW-1:0] = RW'(9);
    #1;
    check_eq("t5_rf9", rdata[XLEN-1:0], ValZ);
    cycle();

    // x0 stays zero; reset during a stall drops the staged write.
    idle();
    wb(0, 0, 64'hBAD);
    issue_valid = 1'b1;
    issue_rd    = '0;
    cycle();
    idle();
    #1;
    check_eq("t6_x0", rdata[XLEN-1:0], '0);
    check_eq("t6_busy0", busy[0], 1'b0);
    cycle();
    idle();
    wb(0, 10, 64'hABC);
    cycle();
    idle();
    commit_stall = 1'b1;
    rst          = 1'b1;
    cycle();
    idle();
    raddr[RW-1:0] = RW'(10);
    #1;
    check_eq("t6_rst_cmt", cmt_valid, '0);
    check_eq("t6_rst_rf10", rdata[XLEN-1:0], '0);
    check_eq("t6_rst_rf5", m_read(5), '0);
    cycle();

    // Randomized traffic on a small register window to force collisions and saturation.
    for (int i = 0; i < 3000; i++) begin
      idle();
      in_valid = NumWb'($urandom);
      in_wen   = NumWb'($urandom);
      for (int c = 0; c < NumWb; c++) begin
        in_rd[c*RW +: RW]       = RW'($urandom_range(0, 7));
        in_data[c*XLEN +: XLEN] = {$urandom, $urandom};
      end
      for (int p = 0; p < NumRd; p++) raddr[p*RW +: RW] = RW'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 19) == 0);
      commit_stall = ($urandom_range(0, 3) == 0);
      issue_valid  = ($urandom_range(0, 1) == 1);
      issue_rd     = RW'($urandom_range(0, 7));
      rst          = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
